dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Fixed-latency single-port data memory responder: IDLE -> BUSY -> RESP handshake.
// Optional protocol checker enabled by defining DMEM_RESPONDER_PROTO_CHECK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          resp_q, resp_d;
  logic          mem_we;

  logic [31:0] mem_array [DEPTH_WORDS];

  // Byte-offset and high address bits never select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[31:AW+2], mem_address[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          idx_d   = mem_address[AW+1:2];
          wr_d    = mem_write;
          wmask_d = mem_wmask;
          wdata_d = mem_wdata;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          resp_d  = 1'b1;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_array[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  // Array is not reset; gating on rst makes a reset during BUSY abort the write.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wmask_q[b]) begin
          mem_array[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = resp_q;

`ifdef DMEM_RESPONDER_PROTO_CHECK_EN
  logic [31:0] addr_q, addr_d;
  logic        perr_q, perr_d;

  always_comb begin
    addr_d = addr_q;
    perr_d = perr_q;
    if (state_q == IDLE && (mem_read || mem_write)) begin
      addr_d = mem_address;
      if (mem_read && mem_write) begin
        perr_d = 1'b1;
      end
    end
    if (state_q == BUSY && ((!mem_read && !mem_write) || mem_address != addr_q)) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q <= '0;
      perr_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      perr_q <= perr_d;
    end
  end

  assign proto_err = perr_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a transaction-level model
// (accept edge + LATENCY = response edge), plus directed literal checks.
module tb_dmem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;
`ifdef DMEM_RESPONDER_PROTO_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_address = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_wmask = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;
  logic [31:0] l1_rdata_unused;
  logic        l1_resp;
  logic        l1_perr_unused;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .proto_err(proto_err));

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(l1_rdata_unused), .mem_resp(l1_resp), .proto_err(l1_perr_unused));

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model state
  int unsigned e = 0;
  int unsigned free_e = 0;
  int unsigned resp_e = 0;
  int unsigned acc_cnt = 0;
  bit          pend = 1'b0;
  bit          p_wr;
  int unsigned p_idx;
  logic [31:0] p_addr;
  logic [3:0]  p_mask;
  logic [31:0] p_data;
  logic [31:0] mm [DEPTH];
  logic [31:0] exp_rdata = '0;
  bit          exp_resp = 1'b0;
  bit          exp_perr = 1'b0;

  // Model step at each rising edge, then compare the DUT just after it.
  initial begin
    forever begin
      @(posedge clk);
      e++;
      exp_resp = 1'b0;
      if (!rst) begin
        pend = 1'b0;
        free_e = e + 1;
        exp_rdata = '0;
        exp_perr = 1'b0;
      end else if (pend) begin
        if (PCHK && ((!mem_read && !mem_write) || mem_address != p_addr)) exp_perr = 1'b1;
        if (e == resp_e) begin
          if (p_wr) begin
            for (int b = 0; b < 4; b++)
              if (p_mask[b]) mm[p_idx][8*b +: 8] = p_data[8*b +: 8];
          end else begin
            exp_rdata = mm[p_idx];
          end
          exp_resp = 1'b1;
          pend = 1'b0;
          free_e = e + 2;
        end
      end else if (e >= free_e && (mem_read || mem_write)) begin
        pend = 1'b1;
        resp_e = e + LAT;
        p_wr = mem_write;
        p_idx = (mem_address / 4) % DEPTH;
        p_addr = mem_address;
        p_mask = mem_wmask;
        p_data = mem_wdata;
        if (PCHK && mem_read && mem_write) exp_perr = 1'b1;
        acc_cnt++;
      end
      #1;
      chk("resp", {31'b0, mem_resp}, {31'b0, exp_resp});
      chk("rdata", mem_rdata, exp_rdata);
      chk("proto_err", {31'b0, proto_err}, {31'b0, exp_perr});
    end
  end

  int unsigned last_lat = 0;

  // Called at a falling edge; holds the request until the response (or abort).
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [3:0] m, input logic [31:0] d, input bit abort);
    int unsigned a0;
    int unsigned ea;
    bit ok;
    a0 = acc_cnt;
    mem_read = rd; mem_write = wr; mem_address = a; mem_wmask = m; mem_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != a0) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    ea = e;
    if (abort) begin
      @(negedge clk);
      rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end else begin
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(posedge clk); #1;
        if (mem_resp) ok = 1'b1;
      end
      if (!ok) chk("resp_timeout", 32'd0, 32'd1);
      last_lat = e - ea;
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  int unsigned l1_edges [$];
  logic [31:0] ra;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rdata", mem_rdata, 32'h0);
    chk("reset_resp", {31'b0, mem_resp}, 32'h0);
    rst = 1'b1;

    txn(1'b0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, 1'b0);
    chk("wr_latency", last_lat, LAT);
    txn(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    chk("rd_latency", last_lat, LAT);
    chk("rd_deadbeef", mem_rdata, 32'hDEADBEEF);
    chk("model_deadbeef", exp_rdata, 32'hDEADBEEF);

    txn(1'b0, 1'b1, 32'h42, 4'b0011, 32'h00001234, 1'b0);
    txn(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    chk("rd_partial", mem_rdata, 32'hDEAD1234);

    txn(1'b0, 1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, 1'b0);
    txn(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    chk("rd_nomask", mem_rdata, 32'hDEAD1234);

    txn(1'b0, 1'b1, 32'h1000, 4'hF, 32'hA5A5A5A5, 1'b0);
    txn(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("rd_wrap", mem_rdata, 32'hA5A5A5A5);

    txn(1'b0, 1'b1, 32'h80, 4'hF, 32'h0, 1'b0);
    txn(1'b0, 1'b1, 32'h80, 4'hF, 32'h11111111, 1'b1);
    txn(1'b1, 1'b0, 32'h80, 4'h0, 32'h0, 1'b0);
    chk("rd_after_abort", mem_rdata, 32'h0);

    txn(1'b1, 1'b1, 32'h8, 4'hF, 32'h5, 1'b0);
    chk("rw_proto", {31'b0, proto_err}, {31'b0, PCHK});
    chk("rw_rdata_held", mem_rdata, 32'h0);
    repeat (4) @(negedge clk);
    chk("rw_proto_sticky", {31'b0, proto_err}, {31'b0, PCHK});
    txn(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0);
    chk("rd_rw_word", mem_rdata, 32'h5);
    pulse_reset();
    @(negedge clk);
    chk("proto_cleared", {31'b0, proto_err}, 32'h0);

    // Held reads: the LATENCY=1 instance must pulse every third cycle.
    mem_read = 1'b1; mem_address = 32'h40;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (l1_resp) l1_edges.push_back(e);
    end
    pulse_reset();
    chk("l1_pulse_count", {31'b0, l1_edges.size() >= 8}, 32'h1);
    for (int i = 1; i < l1_edges.size(); i++)
      chk("l1_gap", l1_edges[i] - l1_edges[i-1], 32'd3);

    for (int i = 0; i < 16; i++)
      txn(1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0);

    for (int n = 0; n < 250; n++) begin
      int unsigned k;
      bit rd, wr;
      k = $urandom_range(0, 9);
      rd = (k < 5) || (k == 9);
      wr = (k >= 5);
      ra = $urandom;
      ra[11:6] = '0;
      ra[5:2] = 4'($urandom_range(0, 15));
      txn(rd, wr, ra, 4'($urandom), $urandom, $urandom_range(0, 19) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
